// File: rtl/hack_loader_pkg.sv
// hack_loader_pkg: definitions shared by the Hack boot path (loader, CPU, ROM).
//   - HACK_ROM_ADDR_WIDTH : instruction ROM address width (depth 2^W words)
//   - LOADER_SYNC_BYTE    : start-of-load marker on the byte stream
//   - loader_state_t      : rom_loader FSM states
package hack_loader_pkg;

  localparam int         HACK_ROM_ADDR_WIDTH = 15;
  localparam logic [7:0] LOADER_SYNC_BYTE    = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/rom_loader.sv
// rom_loader: writes the Hack instruction ROM from a byte stream and holds
// the CPU in reset until a complete program has been committed.
//
// Frame: SYNC, LEN_HI, LEN_LO, N x {DATA_HI, DATA_LO}, [CHECKSUM]
//
// Build option: define ROM_LOADER_CHECKSUM_EN to require a trailing byte
// equal to the mod-256 sum of all data bytes.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   rx_data/valid   received byte stream (never back-pressured)
//   rx_ready        always 1
//   rom_write       one-cycle write strobe, rom_address/rom_data valid with it
//   cpu_reset       CPU reset, low only while the loaded program runs
//   busy/done/error load in progress / program running / last load failed
module rom_loader
  import hack_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = HACK_ROM_ADDR_WIDTH,
  parameter logic [7:0] SYNC_BYTE  = LOADER_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  rom_write,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [15:0]           rom_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  // State entered once the last data word has been accepted.
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam loader_state_t END_ST = ST_CHECK;
`else
  localparam loader_state_t END_ST = ST_RUN;
`endif

  loader_state_t         r_state, w_next;
  logic [7:0]            r_len_hi;
  logic [7:0]            r_data_hi;
  logic [15:0]           r_left;     // words still to be written
  logic [ADDR_WIDTH-1:0] r_addr;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  logic                  r_rx_ready;
  logic                  r_rom_write;
  logic [ADDR_WIDTH-1:0] r_rom_address;
  logic [15:0]           r_rom_data;
  logic                  r_cpu_reset, r_busy, r_done, r_error;

  logic        w_sync;
  logic [15:0] w_len;
  logic        w_too_long;
  logic        w_wr;
  logic        w_commit;
  logic        w_frame_start;
  logic        w_run_d, w_busy_d, w_error_d;

  assign w_sync        = rx_valid && (rx_data == SYNC_BYTE);
  assign w_len         = {r_len_hi, rx_data};
  assign w_too_long    = {16'd0, w_len} > MAX_WORDS;
  assign w_wr          = rx_valid && (r_state == ST_DATA_LO);
  // Last word of the frame is being accepted this edge.
  assign w_commit      = w_wr && (r_left == 16'd1);
  assign w_frame_start = w_sync &&
                         (r_state == ST_IDLE || r_state == ST_RUN || r_state == ST_ERROR);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    if (rx_valid) begin
      case (r_state)
        ST_IDLE, ST_RUN, ST_ERROR: if (w_sync) w_next = ST_LEN_HI;
        ST_LEN_HI:  w_next = ST_LEN_LO;
        ST_LEN_LO: begin
          if (w_len == 16'd0)  w_next = END_ST;
          else if (w_too_long) w_next = ST_ERROR;
          else                 w_next = ST_DATA_HI;
        end
        ST_DATA_HI: w_next = ST_DATA_LO;
        ST_DATA_LO: w_next = (r_left == 16'd1) ? END_ST : ST_DATA_HI;
`ifdef ROM_LOADER_CHECKSUM_EN
        ST_CHECK:   w_next = (rx_data == r_sum) ? ST_RUN : ST_ERROR;
`endif
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  // Decoded from the next state so they register on the same edge as the
  // state. The final-word edge is the exception: the CPU stays in reset for
  // the cycle in which that word's rom_write is still on the bus.
  always_comb begin
    w_run_d   = (w_next == ST_RUN) && !w_commit;
    w_error_d = (w_next == ST_ERROR);
    w_busy_d  = w_commit;
    case (w_next)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: w_busy_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_ready    <= 1'b1;
      r_rom_write   <= 1'b0;
      r_rom_address <= '0;
      r_rom_data    <= '0;
      r_cpu_reset   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_rx_ready  <= 1'b1;
      r_rom_write <= w_wr;
      if (w_wr) begin
        r_rom_address <= r_addr;
        r_rom_data    <= {r_data_hi, rx_data};
      end
      r_cpu_reset <= !w_run_d;
      r_busy      <= w_busy_d;
      r_done      <= w_run_d;
      r_error     <= w_error_d;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_hi  <= '0;
      r_data_hi <= '0;
      r_left    <= '0;
      r_addr    <= '0;
    end else if (rx_valid) begin
      case (r_state)
        ST_LEN_HI:  r_len_hi <= rx_data;
        ST_LEN_LO: begin
          r_left <= w_len;
          r_addr <= '0;
        end
        ST_DATA_HI: r_data_hi <= rx_data;
        ST_DATA_LO: begin
          r_left <= r_left - 16'd1;
          r_addr <= r_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // Only bytes accepted in the data states contribute; a SYNC value inside
  // the payload is data, not a restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_sum <= '0;
    else if (w_frame_start)
      r_sum <= '0;
    else if (rx_valid && (r_state == ST_DATA_HI || r_state == ST_DATA_LO))
      r_sum <= r_sum + rx_data;
  end
`endif

  assign rx_ready    = r_rx_ready;
  assign rom_write   = r_rom_write;
  assign rom_address = r_rom_address;
  assign rom_data    = r_rom_data;
  assign cpu_reset   = r_cpu_reset;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule
